// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: machine-mode CSR file and interrupt/trap sequencer for a
// single M-mode hart. Drives the PC redirect interface (pc_CSR, trap and
// return pulses, WFI hold/wake).
// Optional build macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret
// counters, their read-only user aliases and the instr_retire input.
module csr_irq_ctrl #(
    parameter logic [31:0] MTVEC_BASE = 32'h0001_0000,
    parameter logic [31:0] HARTID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_CPU,
    input  logic        ext_irq,
    input  logic        tmr_irq,
    input  logic [31:0] ex_pc,
    input  logic        is_wfi,
    input  logic        is_mret,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
`ifdef CSR_COUNTERS_EN
    input  logic        instr_retire,
`endif
    output logic [31:0] csr_rdata,
    output logic [31:0] pc_CSR,
    output logic        MEIP_en,
    output logic        MTIP_en,
    output logic        MEIP_end,
    output logic        MTIP_end,
    output logic        WFI_pc_en,
    output logic        WFI_out
);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_SLEEP = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        mie_q, mie_d;         // mstatus.MIE
    logic        mpie_q, mpie_d;       // mstatus.MPIE
    logic        meie_q, meie_d;       // mie.MEIE
    logic        mtie_q, mtie_d;       // mie.MTIE
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        cause_ext_q, cause_ext_d;  // current trap came from ext_irq
    logic [31:0] pc_q, pc_d;                // last driven redirect target

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`endif

    logic        pend_e, pend_t, take, do_mret, do_wfi, wake;
    logic        csr_we;
    logic [31:0] wr_val;

    // Interrupt qualification and the single action chosen this cycle
    always_comb begin
        pend_e  = ext_irq & meie_q;
        pend_t  = tmr_irq & mtie_q;
        take    = mie_q & (pend_e | pend_t) & ~stall_CPU & ~is_mret;
        do_mret = (state_q == S_RUN) & is_mret & ~stall_CPU;
        do_wfi  = (state_q == S_RUN) & ~take & ~do_mret & is_wfi & ~stall_CPU;
        // wake-up ignores both MIE and stall_CPU
        wake    = (state_q == S_SLEEP) & (pend_e | pend_t);
    end

    // Combinational CSR read mux (returns the pre-write value)
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h304: csr_rdata = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            12'h344: csr_rdata = {20'b0, ext_irq, 3'b0, tmr_irq, 7'b0};
            12'h305: csr_rdata = MTVEC_BASE;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'hF14: csr_rdata = HARTID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: csr_rdata = mcycle_q[31:0];
            12'hB80, 12'hC80: csr_rdata = mcycle_q[63:32];
            12'hB02, 12'hC02: csr_rdata = minstret_q[31:0];
            12'hB82, 12'hC82: csr_rdata = minstret_q[63:32];
`endif
            default: csr_rdata = '0;
        endcase
    end

    // CSR instruction write value (RS/RC with zero operand still writes)
    always_comb begin
        csr_we = csr_en & ~stall_CPU & (csr_op != 2'b00);
        case (csr_op)
            2'b01:   wr_val = csr_wdata;
            2'b10:   wr_val = csr_rdata | csr_wdata;
            2'b11:   wr_val = csr_rdata & ~csr_wdata;
            default: wr_val = csr_rdata;
        endcase
    end

    // Redirect interface outputs and sleep FSM next state
    always_comb begin
        MEIP_en   = take & pend_e;
        MTIP_en   = take & ~pend_e;
        MEIP_end  = do_mret & cause_ext_q;
        MTIP_end  = do_mret & ~cause_ext_q;
        WFI_pc_en = (state_q == S_SLEEP) & ~wake;
        WFI_out   = wake;

        pc_CSR = pc_q;
        if (take)         pc_CSR = MTVEC_BASE;
        else if (do_mret) pc_CSR = mepc_q;
        pc_d = pc_CSR;

        state_d = state_q;
        if (do_wfi)    state_d = S_SLEEP;
        else if (wake) state_d = S_RUN;
    end

    // CSR next values: instruction write first, trap/MRET override it
    always_comb begin
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        meie_d      = meie_q;
        mtie_d      = mtie_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        cause_ext_d = cause_ext_q;

        if (csr_we) begin
            case (csr_addr)
                12'h300: begin mie_d  = wr_val[3];  mpie_d = wr_val[7]; end
                12'h304: begin meie_d = wr_val[11]; mtie_d = wr_val[7]; end
                12'h341: mepc_d   = wr_val & ~32'h3;
                12'h342: mcause_d = wr_val;
                default: ;
            endcase
        end

        if (take) begin
            mepc_d      = ex_pc & ~32'h3;
            mcause_d    = pend_e ? {1'b1, 31'd11} : {1'b1, 31'd7};
            mpie_d      = mie_q;
            mie_d       = 1'b0;
            cause_ext_d = pend_e;
        end else if (do_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Counters: a write to either word suppresses that counter's increment
    always_comb begin
        mcycle_d   = mcycle_q;
        minstret_d = minstret_q;
        if (csr_we && csr_addr == 12'hB00)      mcycle_d[31:0]  = wr_val;
        else if (csr_we && csr_addr == 12'hB80) mcycle_d[63:32] = wr_val;
        else if (state_q != S_SLEEP)            mcycle_d = mcycle_q + 64'd1;
        if (csr_we && csr_addr == 12'hB02)      minstret_d[31:0]  = wr_val;
        else if (csr_we && csr_addr == 12'hB82) minstret_d[63:32] = wr_val;
        else if (instr_retire && !stall_CPU)    minstret_d = minstret_q + 64'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    // State and CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            meie_q      <= 1'b0;
            mtie_q      <= 1'b0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            cause_ext_q <= 1'b0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            meie_q      <= meie_d;
            mtie_q      <= mtie_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            cause_ext_q <= cause_ext_d;
            pc_q        <= pc_d;
        end
    end

endmodule

// File: doc/csr_irq_ctrl.md
Name: csr_irq_ctrl

Overview:
- Machine-mode CSR file and interrupt/trap sequencer. It sits beside the program-counter register and drives its redirect interface: pc_CSR, MEIP_en/MEIP_end, MTIP_en/MTIP_end, WFI_pc_en and WFI_out.
- It takes external and timer interrupts, executes WFI and MRET, and services CSR instructions from the EX stage.
- One hart, M-mode only.

Parameters:
- MTVEC_BASE, 32'h0001_0000: trap vector; mtvec reads as this value; direct mode only.
- HARTID, 0: value returned by mhartid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall_CPU  in  1  pipeline stalled; no state changes, no pulses
- ext_irq  in  1  external interrupt level
- tmr_irq  in  1  timer interrupt level
- ex_pc  in  32  PC of the instruction in EX (the next to commit)
- is_wfi  in  1  valid WFI in EX
- is_mret  in  1  valid MRET in EX
- csr_en  in  1  valid CSR instruction in EX
- csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no write
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 or zimm operand
- csr_rdata  out  32  combinational read data (old value)
- pc_CSR  out  32  redirect target
- MEIP_en  out  1  pulse: external-interrupt trap taken
- MTIP_en  out  1  pulse: timer-interrupt trap taken
- MEIP_end  out  1  pulse: MRET returning from an external trap
- MTIP_end  out  1  pulse: MRET returning from a timer trap
- WFI_pc_en  out  1  hold PC (sleeping)
- WFI_out  out  1  one-cycle pulse on wake-up

Behaviour:
- CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] reads 2'b11; other bits read 0.
  - mie 0x304: MEIE[11], MTIE[7].
  - mip 0x344: read-only, MEIP[11]=ext_irq, MTIP[7]=tmr_irq.
  - mtvec 0x305: read-only.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mhartid 0xF14.
  - Unknown addresses read 0; writes to them are ignored.
- Reset: all CSR bits 0, state RUN, all output pulses 0, WFI_pc_en 0, pc_CSR 0.
- Pending definitions:
  - pend_e = ext_irq & MEIE
  - pend_t = tmr_irq & MTIE
  - take = MIE & (pend_e | pend_t) & !stall_CPU & !is_mret
- Priority: external over timer.
- FSM state RUN:
  - take: combinational pulse MEIP_en (or MTIP_en) and pc_CSR = MTVEC_BASE in the same cycle. At the edge: mepc <= ex_pc, mcause <= {1'b1, 31'd11} (or {1'b1, 31'd7}), MPIE <= MIE, MIE <= 0, cause_ext flag <= external.
  - else is_mret & !stall_CPU: pulse MEIP_end if cause_ext, else MTIP_end; pc_CSR = mepc. At the edge: MIE <= MPIE, MPIE <= 1.
  - else is_wfi & !stall_CPU: next state SLEEP.
- FSM state SLEEP:
  - WFI_pc_en = 1.
  - On pend_e | pend_t, regardless of MIE: WFI_pc_en = 0 and WFI_out = 1 for that cycle, next state RUN.
  - If MIE = 1 in that wake-up cycle, the trap is taken in the same cycle (take rule above).
  - stall_CPU does not block wake-up.
- CSR writes (at the edge, csr_en & !stall_CPU & op != 00):
  - RW: new = wdata; RS: new = old | wdata; RC: new = old & ~wdata.
  - RS/RC with wdata = 0 still counts as a write but leaves the value unchanged.
- Collisions:
  - Trap updates of mstatus/mepc/mcause win over a CSR write in the same cycle.
  - MRET updates of mstatus win over a CSR write.
  - MRET and an interrupt in the same cycle: MRET first; the interrupt is taken in the next cycle, once MIE is restored.
- pc_CSR when no pulse is active: holds its last driven value (registered copy), 0 after reset.
- Reset mid-sleep or mid-trap: immediately back to RUN with all CSRs cleared.

Optional Feature:
- CSR_COUNTERS_EN defined:
  - Adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), plus read-only aliases cycle (0xC00/0xC80) and instret (0xC02/0xC82).
  - Additional input instr_retire (1 bit).
  - mcycle increments every cycle except in SLEEP.
  - minstret increments on instr_retire & !stall_CPU.
  - A CSR write to a counter word wins over the increment that cycle.
  - Wrap-around from 2^64-1 to 0.
- Undefined: the port is absent, and those addresses read 0 and ignore writes.

Test Plan:
- Write mstatus = 0x8 and mie = 0x800, then raise ext_irq with ex_pc = 0x120 -> MEIP_en pulses 1 cycle, pc_CSR = 0x0001_0000; afterwards mepc = 0x120, mcause = 0x8000_000B, mstatus = 0x1880.
- After that trap, is_mret -> MEIP_end pulses, pc_CSR = 0x120; afterwards mstatus = 0x1888.
- mie = 0x880, MIE = 1, ext_irq and tmr_irq raised together -> only MEIP_en fires. After MRET with tmr_irq still high -> MTIP_en the following cycle, mcause = 0x8000_0007.
- is_wfi with MIE = 0 and MTIE = 1; 5 idle cycles -> WFI_pc_en = 1 throughout. Then raise tmr_irq -> WFI_out pulses, WFI_pc_en = 0, no MTIP_en.
- Interrupt pending while stall_CPU = 1 for 3 cycles -> no pulses and no CSR changes; trap is taken in the first unstalled cycle.
- With CSR_COUNTERS_EN, preload mcycle = 0xFFFF_FFFF_FFFF_FFFF -> reads 0 next cycle. Write mcycle low word = 5 in a counting cycle -> reads 5, not 6.
